// File: rtl/mem_loader.sv
// mem_loader: streams bytes from a valid/ready source into a byte-wide
// memory starting at BASE_ADDR, optionally reading each byte back to verify.
// Every bus and status output is a register, so strobes are glitch-free.
module mem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'd0,
    parameter int         VERIFY    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] len,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [7:0] mem_in,
    output logic       R,
    output logic       W,
    output logic [7:0] addr,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t     r_state;
    logic [8:0] r_cnt;
    logic [8:0] r_len;
    logic       w_last;

    // Current byte is the final one of the load (len >= 1 here, so no underflow).
    assign w_last = (r_cnt == (r_len - 9'd1));

    // Loader FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            R        <= 1'b1;
            W        <= 1'b1;
            addr     <= '0;
            data_out <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        if (len == 9'd0) begin
                            // Empty load completes immediately without touching the bus.
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            error   <= 1'b0;
                        end else if (len > 9'd256) begin
                            r_state  <= S_ERR;
                            done     <= 1'b0;
                            error    <= 1'b1;
                            err_addr <= BASE_ADDR;
                        end else begin
                            r_state  <= S_ACCEPT;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            r_cnt    <= '0;
                            r_len    <= len;
                            addr     <= BASE_ADDR;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        data_out <= in_data;
                        in_ready <= 1'b0;
                        W        <= 1'b0;
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    W <= 1'b1;
                    if (VERIFY != 0) begin
                        R       <= 1'b0;
                        r_state <= S_CHECK;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt + 9'd1;
                        addr     <= addr + 8'd1;
                        in_ready <= 1'b1;
                        r_state  <= S_ACCEPT;
                    end
                end
                S_CHECK: begin
                    R <= 1'b1;
                    if (mem_in != data_out) begin
                        r_state  <= S_ERR;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        err_addr <= addr;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt + 9'd1;
                        addr     <= addr + 8'd1;
                        in_ready <= 1'b1;
                        r_state  <= S_ACCEPT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: three instances (verify at 0x10, verify at
// 0xFE, no-verify at 0x10), each with its own memory, checked against a
// byte-level model of what a load should leave in memory.
module tb_mem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [8:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_ready, Rv, Wv, busy, done, error;
    logic [7:0] addr_v [3];
    logic [7:0] dout_v [3];
    logic [7:0] eaddr_v [3];
    logic [7:0] memin [3];

    logic [7:0] mem     [3][256];
    logic [7:0] exp_mem [3][256];
    logic       mem_clr;
    logic [2:0] fault_en;
    logic [7:0] fault_a;
    logic [7:0] stream [256];

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int bus_cnt [3] = '{0, 0, 0};
    int rlow    [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    mem_loader #(.BASE_ADDR(8'h10), .VERIFY(1)) u_l0 (
        .clk(clk), .rst(rst), .start(start[0]), .len(len), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready[0]), .mem_in(memin[0]), .R(Rv[0]),
        .W(Wv[0]), .addr(addr_v[0]), .data_out(dout_v[0]), .busy(busy[0]),
        .done(done[0]), .error(error[0]), .err_addr(eaddr_v[0]));
    mem_loader #(.BASE_ADDR(8'hFE), .VERIFY(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start[1]), .len(len), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready[1]), .mem_in(memin[1]), .R(Rv[1]),
        .W(Wv[1]), .addr(addr_v[1]), .data_out(dout_v[1]), .busy(busy[1]),
        .done(done[1]), .error(error[1]), .err_addr(eaddr_v[1]));
    mem_loader #(.BASE_ADDR(8'h10), .VERIFY(0)) u_l2 (
        .clk(clk), .rst(rst), .start(start[2]), .len(len), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready[2]), .mem_in(memin[2]), .R(Rv[2]),
        .W(Wv[2]), .addr(addr_v[2]), .data_out(dout_v[2]), .busy(busy[2]),
        .done(done[2]), .error(error[2]), .err_addr(eaddr_v[2]));

    // Memories: write at the edge that ends a W-low cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_clr) begin
                for (int a = 0; a < 256; a++) mem[k][a] <= 8'(a * 7 + k + 1);
            end else if (!Wv[k]) begin
                mem[k][addr_v[k]] <= dout_v[k];
            end
        end
    end

    // Read path with an optional stuck-at-zero location.
    always_comb begin
        for (int k = 0; k < 3; k++)
            memin[k] = (fault_en[k] && addr_v[k] == fault_a) ? 8'h00 : mem[k][addr_v[k]];
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!Rv[k] && !Wv[k]) viol++;
            if (done[k] && error[k]) viol++;
            if (!Rv[k] || !Wv[k]) bus_cnt[k]++;
            if (!Rv[k]) rlow[k]++;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(int k, string tag);
        chk($sformatf("%s%0d R", tag, k), Rv[k], 1);
        chk($sformatf("%s%0d W", tag, k), Wv[k], 1);
        chk($sformatf("%s%0d addr", tag, k), addr_v[k], 0);
        chk($sformatf("%s%0d data_out", tag, k), dout_v[k], 0);
        chk($sformatf("%s%0d in_ready", tag, k), in_ready[k], 0);
        chk($sformatf("%s%0d busy", tag, k), busy[k], 0);
        chk($sformatf("%s%0d done", tag, k), done[k], 0);
        chk($sformatf("%s%0d error", tag, k), error[k], 0);
        chk($sformatf("%s%0d err_addr", tag, k), eaddr_v[k], 0);
    endtask

    task automatic check_mem(int k, string tag);
        int nm = 0;
        for (int a = 0; a < 256; a++) if (mem[k][a] !== exp_mem[k][a]) nm++;
        chk({tag, " mem"}, nm, 0);
    endtask

    // Reference: what a load of L bytes of stream[] should do to memory k.
    task automatic model_load(int k, int L, bit fen, logic [7:0] fa,
                              output bit e_done, output bit e_err,
                              output logic [7:0] e_ea, output int e_cyc);
        logic [7:0] base;
        bit ver;
        base = (k == 1) ? 8'hFE : 8'h10;
        ver = (k != 2);
        e_done = 0; e_err = 0; e_ea = 0; e_cyc = 0;
        if (L == 0) begin e_done = 1; return; end
        if (L > 256) begin e_err = 1; e_ea = base; return; end
        for (int i = 0; i < L; i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            exp_mem[k][a] = stream[i];
            e_cyc += ver ? 3 : 2;
            if (ver && fen && a == fa && stream[i] != 8'h00) begin
                e_err = 1; e_ea = a; return;
            end
        end
        e_done = 1;
    endtask

    // Drive one load; cyc counts mid-cycle samples with busy high.
    task automatic run_load(int k, int L, bit hold, bit ibusy, output int cyc);
        int idx = 0;
        cyc = 0;
        @(negedge clk);
        start[k] = 1'b1; len = 9'(L); in_data = stream[0];
        in_valid = hold || ($urandom_range(0, 2) != 0);
        @(negedge clk);
        start[k] = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (!Wv[k]) idx++;
            if (!busy[k]) break;
            cyc++;
            start[k] = ibusy && (t == 3);
            if (t == 3 && ibusy) len = 9'd1;
            in_data  = (idx < 256) ? stream[idx] : 8'h00;
            in_valid = (idx < L) && (hold || ($urandom_range(0, 2) != 0));
            @(negedge clk);
        end
        start[k] = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_load(int k, int L, bit hold, bit fen, logic [7:0] fa,
                           bit ibusy, string tag);
        bit ed, ee;
        logic [7:0] ea;
        int ec, cyc, b0, r0;
        fault_en = '0;
        fault_en[k] = fen;
        fault_a = fa;
        model_load(k, L, fen, fa, ed, ee, ea, ec);
        b0 = bus_cnt[k];
        r0 = rlow[k];
        run_load(k, L, hold, ibusy, cyc);
        chk({tag, " done"}, done[k], ed);
        chk({tag, " error"}, error[k], ee);
        if (ee) chk({tag, " err_addr"}, eaddr_v[k], ea);
        chk({tag, " busy"}, busy[k], 0);
        chk({tag, " RW idle"}, {Rv[k], Wv[k]}, 2'b11);
        if (hold) chk({tag, " cycles"}, cyc, ec);
        if (L == 0 || L > 256) chk({tag, " bus quiet"}, bus_cnt[k] - b0, 0);
        if (k == 2) chk({tag, " no reads"}, rlow[k] - r0, 0);
        check_mem(k, tag);
        fault_en = '0;
    endtask

    task automatic fill_stream();
        for (int i = 0; i < 256; i++) stream[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int j, idx, b0;
        rst = 1'b1; start = '0; len = '0; in_valid = 1'b0; in_data = '0;
        fault_en = '0; fault_a = '0; mem_clr = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 256; a++) exp_mem[k][a] = 8'(a * 7 + k + 1);
        #1;
        for (int k = 0; k < 3; k++) check_reset(k, "reset");
        @(negedge clk);
        mem_clr = 1'b0;
        rst = 1'b0;

        // Three bytes at 0x10, source always valid.
        fill_stream();
        stream[0] = 8'hA1; stream[1] = 8'hB2; stream[2] = 8'hC3;
        do_load(0, 3, 1, 0, 8'h00, 0, "basic");
        repeat (3) @(negedge clk);
        chk("basic done holds", done[0], 1);

        // Address wrap from 0xFE.
        fill_stream();
        do_load(1, 4, 1, 0, 8'h00, 0, "wrap");

        // Read-back fault at 0x11.
        stream[0] = 8'hA1; stream[1] = 8'hB2; stream[2] = 8'hC3;
        do_load(0, 3, 1, 1, 8'h11, 0, "fault");

        // Degenerate lengths.
        do_load(0, 0, 1, 0, 8'h00, 0, "len0");
        do_load(0, 300, 1, 0, 8'h00, 0, "len300");

        // No verify: two cycles per byte, no reads.
        fill_stream();
        do_load(2, 2, 1, 0, 8'h00, 0, "nover");

        // Randomized loads.
        for (int n = 0; n < 12; n++) begin
            int k, L;
            bit fen;
            logic [7:0] fa;
            k = $urandom_range(0, 2);
            L = ($urandom_range(0, 7) == 0) ? 256 : $urandom_range(1, 24);
            fen = (k != 2) && ($urandom_range(0, 2) == 0);
            fa = ((k == 1) ? 8'hFE : 8'h10) + 8'($urandom_range(0, L - 1));
            fill_stream();
            do_load(k, L, $urandom_range(0, 3) == 0, fen, fa,
                    $urandom_range(0, 1) == 1, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a WRITE cycle.
        for (int i = 0; i < 256; i++) stream[i] = 8'($urandom_range(1, 255));
        j = $urandom_range(0, 4);
        for (int i = 0; i < j; i++) exp_mem[0][8'h10 + 8'(i)] = stream[i];
        @(negedge clk);
        start[0] = 1'b1; len = 9'd5; in_valid = 1'b1; in_data = stream[0];
        @(negedge clk);
        start[0] = 1'b0;
        idx = 0;
        for (int n = 1; n < 3 * j + 2; n++) begin
            if (!Wv[0]) idx++;
            in_data = stream[idx];
            @(negedge clk);
        end
        chk("rst_mid in WRITE", Wv[0], 0);
        rst = 1'b1;
        #1;
        check_reset(0, "rst_mid");
        b0 = bus_cnt[0];
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid bus quiet", bus_cnt[0] - b0, 0);
        chk("rst_mid busy", busy[0], 0);
        check_mem(0, "rst_mid");

        chk("R/W overlap or done&error", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
